data_plane_seq: RTL and testbench

Sequencer between the GPP and the data plane.
- TX side: streams a GPP-supplied burst of 16-bit words into the data plane TX RAM, raises the transmit request, and waits for completion with a timeout.
- RX side: latches "packet received" and, on GPP request, drains the RX RAM with a fixed-length read burst and a valid strobe.
- Sits between the GPP instruction decode and the data_plane top.

---
 rtl/data_plane_seq_pkg.sv | 31 +++
 rtl/data_plane_seq_rx_reader.sv | 86 ++++++++
 rtl/data_plane_seq.sv | 172 +++++++++++++++++
 tb/tb_data_plane_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_plane_seq_pkg.sv
// Shared types and defaults for the GPP <-> data plane sequencer.
//   tx_state_t / rx_state_t : TX and RX sequencer state encodings
//   WORD_W                  : data plane word width
//   DEF_*                   : default sizing for the sequencer parameters
//   cnt_w()                 : counter width able to hold 0 .. n-1
package data_plane_pkg;

  localparam int WORD_W             = 16;
  localparam int DEF_MAX_WORDS      = 16;
  localparam int DEF_RX_WORDS       = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_LEN_W          = 5;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOAD = 2'd1,
    TX_SEND = 2'd2,
    TX_WAIT = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_AVAIL = 2'd1,
    RX_READ  = 2'd2
  } rx_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_plane_seq_rx_reader.sv
// RX side of the sequencer: remembers that a packet is waiting in the
// data plane RX RAM and, on request, drains it with a fixed-length burst.
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   data_rx_complete_flag   : packet stored in RX RAM (1-cycle pulse)
//   rd_req                  : GPP read-start pulse
//   rx_avail                : a packet is waiting to be read
//   gpp_rtr_dp              : RX RAM read strobe, RX_WORDS consecutive cycles
//   rx_word_valid           : read strobe delayed by the RAM read latency
//   rx_overrun              : packet arrived while the previous one was unread
module dp_rx_reader
  import data_plane_pkg::*;
#(
  parameter int RX_WORDS = DEF_RX_WORDS
) (
  input  logic clk,
  input  logic rst,
  input  logic data_rx_complete_flag,
  input  logic rd_req,
  output logic rx_avail,
  output logic gpp_rtr_dp,
  output logic rx_word_valid,
  output logic rx_overrun
);

  localparam int              RX_W    = cnt_w(RX_WORDS);
  localparam logic [RX_W-1:0] RX_LAST = RX_W'(RX_WORDS - 1);

  rx_state_t       rx_state;
  logic [RX_W-1:0] burst_cnt;
  logic            avail_q;
  logic            overrun_q;
  logic            rtr_p0;
  logic            vld_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state  <= RX_IDLE;
      burst_cnt <= '0;
      avail_q   <= 1'b0;
      overrun_q <= 1'b0;
      rtr_p0    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      // stage p0 -> p1: RAM answers one cycle after the strobe
      vld_p1    <= rtr_p0;
      // A new packet while one is pending or being drained never changes state
      overrun_q <= data_rx_complete_flag && (rx_state != RX_IDLE);
      case (rx_state)
        RX_IDLE: begin
          if (data_rx_complete_flag) begin
            avail_q  <= 1'b1;
            rx_state <= RX_AVAIL;
          end
        end
        RX_AVAIL: begin
          if (rd_req) begin
            avail_q   <= 1'b0;
            rtr_p0    <= 1'b1;
            burst_cnt <= '0;
            rx_state  <= RX_READ;
          end
        end
        RX_READ: begin
          if (burst_cnt == RX_LAST) begin
            rtr_p0   <= 1'b0;
            rx_state <= RX_IDLE;
          end else begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: begin
          avail_q  <= 1'b0;
          rtr_p0   <= 1'b0;
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx_avail      = avail_q;
  assign gpp_rtr_dp    = rtr_p0;
  assign rx_word_valid = vld_p1;
  assign rx_overrun    = overrun_q;

endmodule

// File: rtl/data_plane_seq.sv
// Sequencer between the GPP instruction decode and the data plane.
// TX: streams tx_len GPP words into the data plane TX RAM, raises the
// transmit request and waits for completion or timeout.
// RX: latches packet arrival and drains the RX RAM on GPP request
// (dp_rx_reader).
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   tx_req, tx_len                    : GPP TX start pulse and word count
//   tx_word_valid, tx_word            : GPP word stream
//   tx_word_ready                     : word accepted this cycle
//   gpp_trf_dp, gpp_tx_data           : TX RAM write strobe / data
//   data_tx_flag                      : transmit request level
//   data_tx_complete_flag             : transmit completion pulse
//   tx_busy, tx_done, tx_timeout, tx_err : TX status
//   data_rx_complete_flag             : packet stored in RX RAM
//   rx_avail, rd_req                  : packet waiting / GPP read start
//   gpp_rtr_dp, RAM_rx_data_out       : RX RAM read strobe / read data
//   rx_word_valid, rx_word            : RX word stream to GPP
//   rx_overrun                        : unread packet was overwritten/lost
module data_plane_seq
  import data_plane_pkg::*;
#(
  parameter int MAX_WORDS      = DEF_MAX_WORDS,
  parameter int RX_WORDS       = DEF_RX_WORDS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int LEN_W          = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_req,
  input  logic [LEN_W-1:0]  tx_len,
  input  logic              tx_word_valid,
  input  logic [WORD_W-1:0] tx_word,
  output logic              tx_word_ready,
  output logic              gpp_trf_dp,
  output logic [WORD_W-1:0] gpp_tx_data,
  output logic              data_tx_flag,
  input  logic              data_tx_complete_flag,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_timeout,
  output logic              tx_err,
  input  logic              data_rx_complete_flag,
  output logic              rx_avail,
  input  logic              rd_req,
  output logic              gpp_rtr_dp,
  input  logic [WORD_W-1:0] RAM_rx_data_out,
  output logic              rx_word_valid,
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_overrun
);

  localparam int               TO_W    = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  tx_state_t         tx_state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              ready_q;
  logic              flag_q;
  logic              done_q;
  logic              timeout_q;
  logic              err_q;
  logic              vld_p1;
  logic [WORD_W-1:0] tx_data_p1;

  logic              len_ok;
  logic              tx_accept;

  assign len_ok    = (tx_len != '0) && (tx_len <= MAX_LEN);
  assign tx_accept = ready_q && tx_word_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state   <= TX_IDLE;
      len_q      <= '0;
      word_cnt   <= '0;
      to_cnt     <= '0;
      ready_q    <= 1'b0;
      flag_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
      vld_p1     <= 1'b0;
      tx_data_p1 <= '0;
    end else begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      // stage p0 -> p1: accepted GPP word becomes a TX RAM write
      vld_p1    <= tx_accept;
      if (tx_accept) begin
        tx_data_p1 <= tx_word;
      end
      case (tx_state)
        TX_IDLE: begin
          if (tx_req) begin
            if (len_ok) begin
              len_q    <= tx_len;
              word_cnt <= '0;
              ready_q  <= 1'b1;
              tx_state <= TX_LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        TX_LOAD: begin
          if (tx_accept) begin
            word_cnt <= word_cnt + 1'b1;
            // Ready drops together with the final count so no extra word slips in
            if (word_cnt + 1'b1 == len_q) begin
              ready_q  <= 1'b0;
              tx_state <= TX_SEND;
            end
          end
        end
        TX_SEND: begin
          flag_q   <= 1'b1;
          to_cnt   <= '0;
          tx_state <= TX_WAIT;
        end
        TX_WAIT: begin
          // Completion is tested first so it wins over a same-cycle timeout
          if (data_tx_complete_flag) begin
            flag_q   <= 1'b0;
            done_q   <= 1'b1;
            tx_state <= TX_IDLE;
          end else if (to_cnt == TO_LAST) begin
            flag_q    <= 1'b0;
            timeout_q <= 1'b1;
            tx_state  <= TX_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          ready_q  <= 1'b0;
          flag_q   <= 1'b0;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx_word_ready = ready_q;
  assign gpp_trf_dp    = vld_p1;
  assign gpp_tx_data   = tx_data_p1;
  assign data_tx_flag  = flag_q;
  assign tx_busy       = (tx_state != TX_IDLE);
  assign tx_done       = done_q;
  assign tx_timeout    = timeout_q;
  assign tx_err        = err_q;

  dp_rx_reader #(
    .RX_WORDS (RX_WORDS)
  ) u_rx_reader (
    .clk                   (clk),
    .rst                   (rst),
    .data_rx_complete_flag (data_rx_complete_flag),
    .rd_req                (rd_req),
    .rx_avail              (rx_avail),
    .gpp_rtr_dp            (gpp_rtr_dp),
    .rx_word_valid         (rx_word_valid),
    .rx_overrun            (rx_overrun)
  );

  assign rx_word = RAM_rx_data_out;

endmodule

// File: tb/tb_data_plane_seq.sv
module tb_data_plane_seq;
  import data_plane_pkg::*;

  localparam int LEN_W = 5;
  localparam int TO    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              tx_req;
  logic [LEN_W-1:0]  tx_len;
  logic              tx_word_valid;
  logic [WORD_W-1:0] tx_word;
  logic              tx_word_ready;
  logic              gpp_trf_dp;
  logic [WORD_W-1:0] gpp_tx_data;
  logic              data_tx_flag;
  logic              data_tx_complete_flag;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_timeout;
  logic              tx_err;
  logic              data_rx_complete_flag;
  logic              rx_avail;
  logic              rd_req;
  logic              gpp_rtr_dp;
  logic              rx_word_valid;
  logic [WORD_W-1:0] rx_word;
  logic              rx_overrun;

  always #5 clk = ~clk;

  // RX RAM model: 1-cycle read latency, content derived from a running read index
  int                rd_count = 0;
  logic [WORD_W-1:0] ram_q    = 16'h5A5A;
  always @(posedge clk) begin
    if (gpp_rtr_dp) begin
      ram_q    <= 16'h5000 + rd_count[15:0];
      rd_count <= rd_count + 1;
    end
  end

  data_plane_seq #(
    .MAX_WORDS      (16),
    .RX_WORDS       (16),
    .TIMEOUT_CYCLES (TO),
    .LEN_W          (LEN_W)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .tx_req                (tx_req),
    .tx_len                (tx_len),
    .tx_word_valid         (tx_word_valid),
    .tx_word               (tx_word),
    .tx_word_ready         (tx_word_ready),
    .gpp_trf_dp            (gpp_trf_dp),
    .gpp_tx_data           (gpp_tx_data),
    .data_tx_flag          (data_tx_flag),
    .data_tx_complete_flag (data_tx_complete_flag),
    .tx_busy               (tx_busy),
    .tx_done               (tx_done),
    .tx_timeout            (tx_timeout),
    .tx_err                (tx_err),
    .data_rx_complete_flag (data_rx_complete_flag),
    .rx_avail              (rx_avail),
    .rd_req                (rd_req),
    .gpp_rtr_dp            (gpp_rtr_dp),
    .RAM_rx_data_out       (ram_q),
    .rx_word_valid         (rx_word_valid),
    .rx_word               (rx_word),
    .rx_overrun            (rx_overrun)
  );

  logic [WORD_W-1:0] tx_q[$];
  logic [WORD_W-1:0] rx_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_flag, n_done, n_timeout, n_err, n_trf, n_rtr, n_vld, n_avail, n_overrun, n_busy;
  bit   lag_chk  = 1'b0;
  logic prev_rtr = 1'b0;
  int   base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_flag = 0; n_done = 0; n_timeout = 0; n_err = 0; n_trf = 0;
    n_rtr = 0; n_vld = 0; n_avail = 0; n_overrun = 0; n_busy = 0;
  endtask

  // One clock: outputs sampled 1 time unit after the edge, scoreboards popped on strobes
  task automatic tick();
    @(posedge clk);
    #1;
    if (data_tx_flag)  n_flag++;
    if (tx_done)       n_done++;
    if (tx_timeout)    n_timeout++;
    if (tx_err)        n_err++;
    if (gpp_rtr_dp)    n_rtr++;
    if (rx_avail)      n_avail++;
    if (rx_overrun)    n_overrun++;
    if (tx_busy)       n_busy++;
    if (gpp_trf_dp) begin
      n_trf++;
      check("tx_write_expected", 32'(tx_q.size() != 0), 1);
      if (tx_q.size() != 0) check("tx_word", gpp_tx_data, tx_q.pop_front());
    end
    if (rx_word_valid) begin
      n_vld++;
      check("rx_word_expected", 32'(rx_q.size() != 0), 1);
      if (rx_q.size() != 0) check("rx_word", rx_word, rx_q.pop_front());
    end
    if (lag_chk) check("rx_valid_lag", rx_word_valid, prev_rtr);
    prev_rtr = gpp_rtr_dp;
  endtask

  task automatic wait_flag_rise();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_tx_flag) break;
    end
  endtask

  initial begin
    rst = 1'b0;
    tx_req = 1'b0; tx_len = '0; tx_word_valid = 1'b0; tx_word = '0;
    data_tx_complete_flag = 1'b0; data_rx_complete_flag = 1'b0; rd_req = 1'b0;
    clear_counts();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_trf", gpp_trf_dp, 0);
    check("rst_txdata", gpp_tx_data, 0);
    check("rst_ready", tx_word_ready, 0);
    check("rst_flag", data_tx_flag, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done_to_err", {tx_done, tx_timeout, tx_err}, 0);
    check("rst_rx", {rx_avail, gpp_rtr_dp, rx_word_valid, rx_overrun}, 0);
    check("rst_rx_word", rx_word, ram_q);
    rst = 1'b1;
    tick();

    // Normal TX, 3 words, completion in the 5th WAIT cycle
    clear_counts();
    tx_req = 1'b1; tx_len = 5'd3;
    tx_q.push_back(16'h00A1); tx_q.push_back(16'h00B2); tx_q.push_back(16'h00C3);
    tick();
    tx_req = 1'b0;
    check("tx_busy_load", tx_busy, 1);
    check("tx_ready_load", tx_word_ready, 1);
    tx_word_valid = 1'b1; tx_word = 16'h00A1;
    tick();
    tx_word = 16'h00B2;
    tick();
    tx_word = 16'h00C3;
    tick();
    tx_word_valid = 1'b0;
    check("tx_ready_drop", tx_word_ready, 0);
    wait_flag_rise();
    check("tx_flag_rise", data_tx_flag, 1);
    repeat (4) tick();
    data_tx_complete_flag = 1'b1;
    tick();
    data_tx_complete_flag = 1'b0;
    check("tx_done_pulse", tx_done, 1);
    check("tx_flag_drop", data_tx_flag, 0);
    repeat (3) tick();
    check("tx_flag_cycles", n_flag, 5);
    check("tx_done_count", n_done, 1);
    check("tx_write_count", n_trf, 3);
    check("tx_busy_after", tx_busy, 0);

    // Illegal lengths
    clear_counts();
    tx_req = 1'b1; tx_len = 5'd0;
    tick();
    tx_req = 1'b0;
    check("err_len0", tx_err, 1);
    tick();
    check("err_len0_clear", tx_err, 0);
    tx_req = 1'b1; tx_len = 5'd17;
    tick();
    tx_req = 1'b0;
    check("err_len17", tx_err, 1);
    repeat (3) tick();
    check("err_count", n_err, 2);
    check("err_no_write", n_trf, 0);
    check("err_busy", n_busy, 0);

    // Timeout
    clear_counts();
    tx_req = 1'b1; tx_len = 5'd1;
    tick();
    tx_req = 1'b0;
    tx_word_valid = 1'b1; tx_word = 16'h1234; tx_q.push_back(16'h1234);
    tick();
    tx_word_valid = 1'b0;
    wait_flag_rise();
    check("to_flag_rise", data_tx_flag, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!data_tx_flag) break;
    end
    check("to_flag_drop", data_tx_flag, 0);
    check("to_pulse", tx_timeout, 1);
    check("to_flag_cycles", n_flag, TO);
    check("to_busy", tx_busy, 0);
    data_tx_complete_flag = 1'b1;
    tick();
    data_tx_complete_flag = 1'b0;
    repeat (3) tick();
    check("to_late_done", n_done, 0);
    check("to_late_flag", data_tx_flag, 0);
    check("to_count", n_timeout, 1);

    // RX read
    clear_counts();
    data_rx_complete_flag = 1'b1;
    tick();
    data_rx_complete_flag = 1'b0;
    check("rx_avail_set", rx_avail, 1);
    tick();
    rd_req = 1'b1;
    base = rd_count;
    for (int k = 0; k < 16; k++) rx_q.push_back(16'h5000 + 16'(base + k));
    tick();
    rd_req = 1'b0;
    lag_chk = 1'b1;
    check("rx_avail_drop", rx_avail, 0);
    check("rx_rtr_start", gpp_rtr_dp, 1);
    repeat (20) tick();
    check("rx_avail_cycles", n_avail, 2);
    check("rx_rtr_cycles", n_rtr, 16);
    check("rx_vld_cycles", n_vld, 16);
    check("rx_queue_empty", rx_q.size(), 0);
    check("rx_no_overrun", n_overrun, 0);

    // Overrun during read
    clear_counts();
    data_rx_complete_flag = 1'b1;
    tick();
    data_rx_complete_flag = 1'b0;
    tick();
    rd_req = 1'b1;
    base = rd_count;
    for (int k = 0; k < 16; k++) rx_q.push_back(16'h5000 + 16'(base + k));
    tick();
    rd_req = 1'b0;
    repeat (3) tick();
    data_rx_complete_flag = 1'b1;
    tick();
    data_rx_complete_flag = 1'b0;
    check("ovr_pulse", rx_overrun, 1);
    tick();
    check("ovr_pulse_clear", rx_overrun, 0);
    repeat (20) tick();
    check("ovr_count", n_overrun, 1);
    check("ovr_rtr_cycles", n_rtr, 16);
    check("ovr_vld_cycles", n_vld, 16);
    check("ovr_packet_lost", rx_avail, 0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    check("ovr_idle_rd_ignored", gpp_rtr_dp, 0);

    // Concurrent TX load and RX read, reset at TX word 2
    clear_counts();
    data_rx_complete_flag = 1'b1;
    tick();
    data_rx_complete_flag = 1'b0;
    tx_req = 1'b1; tx_len = 5'd4; rd_req = 1'b1;
    base = rd_count;
    for (int k = 0; k < 16; k++) rx_q.push_back(16'h5000 + 16'(base + k));
    tick();
    tx_req = 1'b0; rd_req = 1'b0;
    check("cc_ready", tx_word_ready, 1);
    check("cc_rtr", gpp_rtr_dp, 1);
    tx_word_valid = 1'b1; tx_word = 16'h00D0; tx_q.push_back(16'h00D0);
    tick();
    tx_word = 16'h00D1; tx_q.push_back(16'h00D1);
    tick();
    tx_word_valid = 1'b0;
    lag_chk = 1'b0;
    rst = 1'b0;
    #1;
    check("cc_rst_outputs",
          {gpp_trf_dp, tx_word_ready, data_tx_flag, tx_busy, gpp_rtr_dp, rx_word_valid, rx_avail}, 0);
    check("cc_rst_txdata", gpp_tx_data, 0);
    check("cc_tx_writes", n_trf, 2);
    check("cc_rx_words", n_vld, 2);
    check("cc_tx_queue", tx_q.size(), 0);
    rx_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    clear_counts();
    repeat (10) tick();
    check("post_rst_no_trf", n_trf, 0);
    check("post_rst_no_rtr", n_rtr + n_vld, 0);
    check("post_rst_no_flag", n_flag, 0);

    // Recovery: a fresh single-word TX after reset
    clear_counts();
    tx_req = 1'b1; tx_len = 5'd1;
    tick();
    tx_req = 1'b0;
    tx_word_valid = 1'b1; tx_word = 16'h00EE; tx_q.push_back(16'h00EE);
    tick();
    tx_word_valid = 1'b0;
    wait_flag_rise();
    data_tx_complete_flag = 1'b1;
    tick();
    data_tx_complete_flag = 1'b0;
    check("rec_done", tx_done, 1);
    check("rec_writes", n_trf, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
